execute_x_pipe: RTL and testbench
=================================

# execute_x_pipe

Parametrised integer execute pipeline for the X functional unit. Accepts one issued instruction per cycle when the issue slot targets this unit, computes the ALU or shifter result in stage 0, then carries the result through DEPTH-1 register stages to writeback. Adds writeback back-pressure (hold), pipeline flush, a pending-write scoreboard for issue hazard checks, and an overflow-exception flag.

## Interface
- WIDTH, 32, datapath width; power of two, at least 8.
- DEPTH, 4, total stages including the compute stage; at least 1.
- REGBITS, 5, register-index width.
- FUNIT_ID, 1, value of is_x_functionalunit that selects this unit.
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset.
- is_x_functionalunit  in  2  issue target; the instruction is valid when it equals FUNIT_ID.
- is_x_selalushift  in  1  0 selects ALU result, 1 selects shifter result.
- is_x_selimregb  in  1  1 selects ALU operand B = is_x_imedext, 0 selects is_x_regb.
- is_x_aluop  in  3  ALU operation.
- is_x_unsig  in  1  unsigned compare; suppresses overflow.
- is_x_shiftop  in  2  shift operation.
- is_x_shiftamt  in  log2(WIDTH)  shift amount.
- is_x_rega, is_x_regb, is_x_imedext  in  WIDTH  operands.
- is_x_regdest  in  REGBITS  destination register.
- is_x_writereg  in  1  instruction writes a register.
- is_x_writeov  in  1  write even when overflow occurs.
- x_flush  in  1  kill every in-flight instruction and the current issue.
- wb_hold  in  1  writeback cannot accept; freeze the pipe.
- x_ready  out  1  equals !wb_hold; issue is accepted only when 1.
- x_wb_valid  out  1  final stage holds a valid instruction.
- x_wb_regdest  out  REGBITS  destination register.
- x_wb_writereg  out  1  register write enable.
- x_wb_wbvalue  out  WIDTH  result.
- x_wb_overflow  out  1  signed overflow occurred and is_x_writeov was 0.
- x_busy  out  2**REGBITS  bit r set while any valid stage holds writereg=1 and regdest=r; bit 0 is always 0.

## Operation
- Accept: is_x_functionalunit==FUNIT_ID && x_ready && !x_flush. A cycle without an accept loads a bubble into stage 0.
- Bubble and invalid stages hold valid=0, regdest=0, writereg=0, wbvalue=0, overflow=0.
- ALU operation codes (B is the selected operand):
  - 000 add; 001 sub; 010 and; 011 or; 100 xor; 101 nor.
  - 110 set-less-than, giving 1 or 0. The compare is signed unless is_x_unsig=1.
  - 111 pass B.
- Overflow: signed overflow of add or sub when is_x_unsig=0; 0 for every other operation.
- Shifter operates on regb by shiftamt:
  - 00 sll; 01 srl; 10 sra.
  - 11 rotate right (new). A rotate amount of 0 returns regb unchanged.
- Stage 0 stores:
  - writereg = is_x_writereg & (!ov | is_x_writeov).
  - overflow = ov & !is_x_writeov.
  - wbvalue = the shifter or ALU result, as chosen by is_x_selalushift, computed modulo 2**WIDTH.
- Stages 1..DEPTH-1 copy the previous stage unchanged. The final stage drives the x_wb_* outputs.
- Hold: while wb_hold=1 and x_flush=0, every stage keeps its value and issue is refused.
- Flush: on the cycle after x_flush=1, every stage is a bubble and x_busy=0. Flush overrides hold and overrides an issue in the same cycle.
- x_busy is combinational from stage contents, so an instruction's bit is set from the cycle after it is accepted.

## Timing
- Reset (reset=0 at an edge): all stages become bubbles. All outputs are 0 except x_ready, which follows wb_hold.
- Reset asserted mid-operation discards in-flight instructions with no writeback. Reset has priority over flush and hold.
- Latency: an instruction accepted at edge N appears at x_wb_* after edge N+DEPTH-1, i.e. valid during cycle N+DEPTH, when no hold occurs. DEPTH=1 gives next-cycle output.
- Each hold cycle adds exactly one cycle of latency. x_wb_* stay stable and valid throughout the hold.
- Throughput: 1 instruction per cycle with no hold.
- Same-destination instructions in flight: x_busy stays set until the last of them leaves the final stage.

## Test plan
- Latency, DEPTH=4, WIDTH=32: issue add with rega=5, regb=7, regdest=3, writereg=1 at edge 0 -> x_wb_valid=1, wbvalue=12, regdest=3 after edge 3. x_busy[3]=1 from edge 0 until the value leaves.
- Overflow: add with 0x7FFFFFFF + 1, writeov=0 -> wbvalue=0x80000000, writereg=0, overflow=1. Repeat with writeov=1 -> writereg=1, overflow=0. Repeat with unsig=1 -> no overflow.
- Shifter: regb=0x80000001, shiftamt=4 -> sra gives 0xF8000000, rotr gives 0x18000000, srl gives 0x08000000. slt with -1 < 1 -> 1 signed, 0 with unsig=1.
- Hold: issue 3 back-to-back instructions, then hold for 2 cycles while the first is at the output -> x_wb_* frozen, x_ready=0, and an issue during the hold is dropped. After release the remaining two appear on consecutive cycles.
- Flush: with 3 instructions in flight plus a concurrent issue and wb_hold=1, pulse x_flush -> next cycle x_busy=0 and no x_wb_valid for DEPTH cycles.
- Reset and parameters: assert reset with the pipe full -> all outputs 0 the next cycle. Rerun the latency test at DEPTH=1 and at WIDTH=16.

Source files
------------

// File: rtl/execute_x_pipe_if.sv
// ---------------------------------------------------------------------------
// execute_x_pipe_if
//
// Bundles the issue slot, flush/hold controls, writeback outputs and the
// pending-write scoreboard of the X functional-unit execute pipeline.
//
//   master : issue-stage / control side (drives issue fields, x_flush,
//            wb_hold; observes x_ready, x_wb_*, x_busy)
//   slave  : the execute pipeline itself
//
// Parameters must match the connected execute_x_pipe instance.
// ---------------------------------------------------------------------------
interface execute_x_pipe_if #(
   parameter int WIDTH   = 32,
   parameter int REGBITS = 5
);
   localparam int SHW = $clog2(WIDTH);

   // issue slot
   logic [1:0]              is_x_functionalunit;
   logic                    is_x_selalushift;
   logic                    is_x_selimregb;
   logic [2:0]              is_x_aluop;
   logic                    is_x_unsig;
   logic [1:0]              is_x_shiftop;
   logic [SHW-1:0]          is_x_shiftamt;
   logic [WIDTH-1:0]        is_x_rega;
   logic [WIDTH-1:0]        is_x_regb;
   logic [WIDTH-1:0]        is_x_imedext;
   logic [REGBITS-1:0]      is_x_regdest;
   logic                    is_x_writereg;
   logic                    is_x_writeov;

   // pipeline control
   logic                    x_flush;
   logic                    wb_hold;
   logic                    x_ready;

   // writeback
   logic                    x_wb_valid;
   logic [REGBITS-1:0]      x_wb_regdest;
   logic                    x_wb_writereg;
   logic [WIDTH-1:0]        x_wb_wbvalue;
   logic                    x_wb_overflow;

   // scoreboard
   logic [2**REGBITS-1:0]   x_busy;

   modport master (
      output is_x_functionalunit, is_x_selalushift, is_x_selimregb, is_x_aluop,
             is_x_unsig, is_x_shiftop, is_x_shiftamt, is_x_rega, is_x_regb,
             is_x_imedext, is_x_regdest, is_x_writereg, is_x_writeov,
             x_flush, wb_hold,
      input  x_ready, x_wb_valid, x_wb_regdest, x_wb_writereg, x_wb_wbvalue,
             x_wb_overflow, x_busy
   );

   modport slave (
      input  is_x_functionalunit, is_x_selalushift, is_x_selimregb, is_x_aluop,
             is_x_unsig, is_x_shiftop, is_x_shiftamt, is_x_rega, is_x_regb,
             is_x_imedext, is_x_regdest, is_x_writereg, is_x_writeov,
             x_flush, wb_hold,
      output x_ready, x_wb_valid, x_wb_regdest, x_wb_writereg, x_wb_wbvalue,
             x_wb_overflow, x_busy
   );
endinterface

// File: rtl/execute_x_pipe.sv
// ---------------------------------------------------------------------------
// execute_x_pipe
//
// Integer execute pipeline for the X functional unit. Stage 0 computes the
// ALU or shifter result of the issued instruction; stages 1..DEPTH-1 carry
// it unchanged to writeback. Supports writeback hold (whole pipe freezes),
// flush (whole pipe becomes bubbles), a pending-write scoreboard and an
// overflow-exception flag.
//
// Ports:
//   clock  : sole clock, rising edge
//   reset  : synchronous, active-low; clears every stage
//   xif    : execute_x_pipe_if.slave
//              issue   : is_x_* fields, accepted when
//                        is_x_functionalunit==FUNIT_ID, x_ready, !x_flush
//              control : x_flush, wb_hold, x_ready (= !wb_hold)
//              wb      : x_wb_valid/regdest/writereg/wbvalue/overflow from
//                        the final stage
//              x_busy  : one bit per register with a pending write
// ---------------------------------------------------------------------------
module execute_x_pipe #(
   parameter int         WIDTH    = 32,
   parameter int         DEPTH    = 4,
   parameter int         REGBITS  = 5,
   parameter logic [1:0] FUNIT_ID = 2'd1
) (
   input logic             clock,
   input logic             reset,
   execute_x_pipe_if.slave xif
);

   localparam int SHW  = $clog2(WIDTH);
   localparam int NREG = 2**REGBITS;

   // ------------------------------------------------------------------
   // helper functions
   // ------------------------------------------------------------------
   function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                    input logic signed [WIDTH-1:0] b,
                                    input logic signed [WIDTH-1:0] r);
      return (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
   endfunction

   function automatic logic sub_ovf(input logic signed [WIDTH-1:0] a,
                                    input logic signed [WIDTH-1:0] b,
                                    input logic signed [WIDTH-1:0] r);
      return (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
   endfunction

   // Rotate right: shifting a doubled copy keeps amount 0 an identity
   // and avoids a WIDTH-amt shift that would overflow the amount field.
   function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] v,
                                             input logic [SHW-1:0]   amt);
      return WIDTH'({v, v} >> amt);
   endfunction

   // ------------------------------------------------------------------
   // stage 0 : operand select, ALU, shifter, overflow
   // ------------------------------------------------------------------
   logic                      accept_p0;
   logic signed [WIDTH-1:0]   opa_p0;
   logic signed [WIDTH-1:0]   opb_p0;
   logic signed [WIDTH-1:0]   sum_p0;
   logic signed [WIDTH-1:0]   diff_p0;
   logic signed [WIDTH-1:0]   alu_res_p0;
   logic signed [WIDTH-1:0]   shv_p0;
   logic signed [WIDTH-1:0]   sh_res_p0;
   logic signed [WIDTH-1:0]   res_p0;
   logic                      lt_p0;
   logic                      ov_p0;

   assign accept_p0 = (xif.is_x_functionalunit == FUNIT_ID) &&
                      !xif.wb_hold && !xif.x_flush;

   always_comb begin
      opa_p0  = xif.is_x_rega;
      opb_p0  = xif.is_x_selimregb ? xif.is_x_imedext : xif.is_x_regb;
      sum_p0  = opa_p0 + opb_p0;
      diff_p0 = opa_p0 - opb_p0;
      lt_p0   = xif.is_x_unsig ? ($unsigned(opa_p0) < $unsigned(opb_p0))
                               : (opa_p0 < opb_p0);

      alu_res_p0 = '0;
      case (xif.is_x_aluop)
         3'd0: alu_res_p0 = sum_p0;
         3'd1: alu_res_p0 = diff_p0;
         3'd2: alu_res_p0 = opa_p0 & opb_p0;
         3'd3: alu_res_p0 = opa_p0 | opb_p0;
         3'd4: alu_res_p0 = opa_p0 ^ opb_p0;
         3'd5: alu_res_p0 = ~(opa_p0 | opb_p0);
         3'd6: alu_res_p0[0] = lt_p0;
         default: alu_res_p0 = opb_p0;
      endcase

      // Overflow is only meaningful for a signed add/sub whose result is
      // actually selected for writeback.
      ov_p0 = 1'b0;
      if (!xif.is_x_selalushift && !xif.is_x_unsig) begin
         if (xif.is_x_aluop == 3'd0)
            ov_p0 = add_ovf(opa_p0, opb_p0, sum_p0);
         else if (xif.is_x_aluop == 3'd1)
            ov_p0 = sub_ovf(opa_p0, opb_p0, diff_p0);
      end

      shv_p0    = xif.is_x_regb;
      sh_res_p0 = '0;
      case (xif.is_x_shiftop)
         2'd0:    sh_res_p0 = shv_p0 << xif.is_x_shiftamt;
         2'd1:    sh_res_p0 = $signed($unsigned(shv_p0) >> xif.is_x_shiftamt);
         2'd2:    sh_res_p0 = shv_p0 >>> xif.is_x_shiftamt;
         default: sh_res_p0 = rotr(xif.is_x_regb, xif.is_x_shiftamt);
      endcase

      res_p0 = xif.is_x_selalushift ? sh_res_p0 : alu_res_p0;
   end

   // ------------------------------------------------------------------
   // stages 0..DEPTH-1 : pipeline registers
   // ------------------------------------------------------------------
   logic                    vld_p   [DEPTH];
   logic [REGBITS-1:0]      dest_p  [DEPTH];
   logic                    wr_p    [DEPTH];
   logic signed [WIDTH-1:0] val_p   [DEPTH];
   logic                    ovf_p   [DEPTH];

   // Reset and flush both turn every stage into an all-zero bubble; hold
   // freezes the whole pipe. A non-accepted cycle loads a bubble so that
   // stale operand values never reach the writeback outputs.
   always_ff @(posedge clock) begin
      if (!reset || xif.x_flush) begin
         for (int s = 0; s < DEPTH; s++) begin
            vld_p[s]  <= 1'b0;
            dest_p[s] <= '0;
            wr_p[s]   <= 1'b0;
            val_p[s]  <= '0;
            ovf_p[s]  <= 1'b0;
         end
      end else if (!xif.wb_hold) begin
         vld_p[0]  <= accept_p0;
         dest_p[0] <= accept_p0 ? xif.is_x_regdest : '0;
         wr_p[0]   <= accept_p0 & xif.is_x_writereg & (!ov_p0 | xif.is_x_writeov);
         val_p[0]  <= accept_p0 ? res_p0 : '0;
         ovf_p[0]  <= accept_p0 & ov_p0 & !xif.is_x_writeov;
         for (int s = 1; s < DEPTH; s++) begin
            vld_p[s]  <= vld_p[s-1];
            dest_p[s] <= dest_p[s-1];
            wr_p[s]   <= wr_p[s-1];
            val_p[s]  <= val_p[s-1];
            ovf_p[s]  <= ovf_p[s-1];
         end
      end
   end

   // ------------------------------------------------------------------
   // scoreboard and writeback outputs
   // ------------------------------------------------------------------
   logic [NREG-1:0] busy;

   // Several in-flight writes to one register simply OR together, so the
   // bit stays set until the last of them leaves. r0 is never pending.
   always_comb begin
      busy = '0;
      for (int s = 0; s < DEPTH; s++) begin
         if (vld_p[s] && wr_p[s])
            busy[dest_p[s]] = 1'b1;
      end
      busy[0] = 1'b0;
   end

   assign xif.x_busy        = busy;
   assign xif.x_ready       = !xif.wb_hold;
   assign xif.x_wb_valid    = vld_p[DEPTH-1];
   assign xif.x_wb_regdest  = dest_p[DEPTH-1];
   assign xif.x_wb_writereg = wr_p[DEPTH-1];
   assign xif.x_wb_wbvalue  = val_p[DEPTH-1];
   assign xif.x_wb_overflow = ovf_p[DEPTH-1];

endmodule

// File: tb/tb_execute_x_pipe.sv
module tb_execute_x_pipe;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   // ia: WIDTH=32 DEPTH=4, ib: WIDTH=32 DEPTH=1, ic: WIDTH=16 DEPTH=4
   execute_x_pipe_if #(.WIDTH(32), .REGBITS(5)) ia ();
   execute_x_pipe_if #(.WIDTH(32), .REGBITS(5)) ib ();
   execute_x_pipe_if #(.WIDTH(16), .REGBITS(5)) ic ();

   execute_x_pipe #(.WIDTH(32), .DEPTH(4), .REGBITS(5), .FUNIT_ID(2'd1))
      dut_a (.clock(clock), .reset(reset), .xif(ia));
   execute_x_pipe #(.WIDTH(32), .DEPTH(1), .REGBITS(5), .FUNIT_ID(2'd1))
      dut_b (.clock(clock), .reset(reset), .xif(ib));
   execute_x_pipe #(.WIDTH(16), .DEPTH(4), .REGBITS(5), .FUNIT_ID(2'd1))
      dut_c (.clock(clock), .reset(reset), .xif(ic));

   logic [1:0]  d_funit;
   logic        d_sh, d_sel, d_uns, d_wr, d_wov, d_flush, d_hold;
   logic [2:0]  d_op;
   logic [1:0]  d_shop;
   logic [4:0]  d_amt, d_dest;
   logic [31:0] d_a, d_b, d_imm;

   assign ia.is_x_functionalunit = d_funit;  assign ib.is_x_functionalunit = d_funit;
   assign ia.is_x_selalushift = d_sh;         assign ib.is_x_selalushift = d_sh;
   assign ia.is_x_selimregb = d_sel;          assign ib.is_x_selimregb = d_sel;
   assign ia.is_x_aluop = d_op;               assign ib.is_x_aluop = d_op;
   assign ia.is_x_unsig = d_uns;              assign ib.is_x_unsig = d_uns;
   assign ia.is_x_shiftop = d_shop;           assign ib.is_x_shiftop = d_shop;
   assign ia.is_x_shiftamt = d_amt;           assign ib.is_x_shiftamt = d_amt;
   assign ia.is_x_rega = d_a;                 assign ib.is_x_rega = d_a;
   assign ia.is_x_regb = d_b;                 assign ib.is_x_regb = d_b;
   assign ia.is_x_imedext = d_imm;            assign ib.is_x_imedext = d_imm;
   assign ia.is_x_regdest = d_dest;           assign ib.is_x_regdest = d_dest;
   assign ia.is_x_writereg = d_wr;            assign ib.is_x_writereg = d_wr;
   assign ia.is_x_writeov = d_wov;            assign ib.is_x_writeov = d_wov;
   assign ia.x_flush = d_flush;               assign ib.x_flush = d_flush;
   assign ia.wb_hold = d_hold;                assign ib.wb_hold = d_hold;

   assign ic.is_x_functionalunit = d_funit;
   assign ic.is_x_selalushift = d_sh;
   assign ic.is_x_selimregb = d_sel;
   assign ic.is_x_aluop = d_op;
   assign ic.is_x_unsig = d_uns;
   assign ic.is_x_shiftop = d_shop;
   assign ic.is_x_shiftamt = d_amt[3:0];
   assign ic.is_x_rega = d_a[15:0];
   assign ic.is_x_regb = d_b[15:0];
   assign ic.is_x_imedext = d_imm[15:0];
   assign ic.is_x_regdest = d_dest;
   assign ic.is_x_writereg = d_wr;
   assign ic.is_x_writeov = d_wov;
   assign ic.x_flush = d_flush;
   assign ic.wb_hold = d_hold;

   typedef struct {
      logic [31:0] sh, sel, op, uns, shop, amt, a, b, imm, dest, wr, wov, ev, ew, eo;
   } instr_t;

   instr_t tab[$];
   int checks = 0;
   int failures = 0;

   function automatic instr_t row(input logic [31:0] sh, sel, op, uns, shop, amt,
                                  a, b, imm, dest, wr, wov, ev, ew, eo);
      instr_t t;
      t.sh = sh; t.sel = sel; t.op = op; t.uns = uns; t.shop = shop; t.amt = amt;
      t.a = a; t.b = b; t.imm = imm; t.dest = dest; t.wr = wr; t.wov = wov;
      t.ev = ev; t.ew = ew; t.eo = eo;
      return t;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_ins(input instr_t t);
      d_funit = 2'd1;
      d_sh = t.sh[0]; d_sel = t.sel[0]; d_op = t.op[2:0]; d_uns = t.uns[0];
      d_shop = t.shop[1:0]; d_amt = t.amt[4:0];
      d_a = t.a; d_b = t.b; d_imm = t.imm;
      d_dest = t.dest[4:0]; d_wr = t.wr[0]; d_wov = t.wov[0];
   endtask

   // pass-B instruction writing value v to register r
   function automatic instr_t pb(input logic [31:0] v, input logic [31:0] r);
      return row(0, 0, 7, 0, 0, 0, 0, v, 0, r, 1, 0, v, 1, 0);
   endfunction

   task automatic exp_wb(input string tag, input logic [31:0] v, d, w, val, o);
      chk({tag, ".valid"},    32'(ia.x_wb_valid),    v);
      chk({tag, ".regdest"},  32'(ia.x_wb_regdest),  d);
      chk({tag, ".writereg"}, 32'(ia.x_wb_writereg), w);
      chk({tag, ".wbvalue"},  32'(ia.x_wb_wbvalue),  val);
      chk({tag, ".overflow"}, 32'(ia.x_wb_overflow), o);
   endtask

   initial begin
      d_funit = 2'd0; d_sh = 0; d_sel = 0; d_op = 3'd0; d_uns = 0; d_shop = 2'd0;
      d_amt = 5'd0; d_a = 0; d_b = 0; d_imm = 0; d_dest = 5'd0; d_wr = 0; d_wov = 0;
      d_flush = 0; d_hold = 0;

      //                  sh sel op uns shop amt a              b              imm            dest wr wov ev             ew eo
      tab.push_back(row(0, 0, 0, 0, 0, 0, 5,             7,             0,             3,  1, 0, 12,            1, 0));
      tab.push_back(row(0, 0, 0, 0, 0, 0, 32'h7FFFFFFF,  1,             0,             4,  1, 0, 32'h80000000,  0, 1));
      tab.push_back(row(0, 0, 0, 0, 0, 0, 32'h7FFFFFFF,  1,             0,             5,  1, 1, 32'h80000000,  1, 0));
      tab.push_back(row(0, 0, 0, 1, 0, 0, 32'h7FFFFFFF,  1,             0,             6,  1, 0, 32'h80000000,  1, 0));
      tab.push_back(row(0, 0, 1, 0, 0, 0, 32'h80000000,  1,             0,             7,  1, 0, 32'h7FFFFFFF,  0, 1));
      tab.push_back(row(0, 1, 2, 0, 0, 0, 32'hF0F0F0F0,  0,             32'hFF00FF00,  8,  1, 0, 32'hF000F000,  1, 0));
      tab.push_back(row(0, 0, 3, 0, 0, 0, 32'hF0F0F0F0,  32'h0F0F0000,  0,             9,  1, 0, 32'hFFFFF0F0,  1, 0));
      tab.push_back(row(0, 0, 4, 0, 0, 0, 32'hF0F0F0F0,  32'hFFFFFFFF,  0,             10, 1, 0, 32'h0F0F0F0F,  1, 0));
      tab.push_back(row(0, 0, 5, 0, 0, 0, 32'hF0F0F0F0,  32'h0F0F0000,  0,             11, 1, 0, 32'h00000F0F,  1, 0));
      tab.push_back(row(0, 0, 6, 0, 0, 0, 32'hFFFFFFFF,  1,             0,             12, 1, 0, 1,             1, 0));
      tab.push_back(row(0, 0, 6, 1, 0, 0, 32'hFFFFFFFF,  1,             0,             13, 1, 0, 0,             1, 0));
      tab.push_back(row(0, 0, 6, 0, 0, 0, 1,             32'hFFFFFFFF,  0,             14, 1, 0, 0,             1, 0));
      tab.push_back(row(0, 0, 6, 1, 0, 0, 1,             32'hFFFFFFFF,  0,             15, 1, 0, 1,             1, 0));
      tab.push_back(row(0, 1, 7, 0, 0, 0, 0,             32'hDEADBEEF,  32'h12345678,  16, 1, 0, 32'h12345678,  1, 0));
      tab.push_back(row(1, 0, 0, 0, 0, 4, 0,             32'h80000001,  0,             17, 1, 0, 32'h00000010,  1, 0));
      tab.push_back(row(1, 0, 0, 0, 1, 4, 0,             32'h80000001,  0,             18, 1, 0, 32'h08000000,  1, 0));
      tab.push_back(row(1, 0, 0, 0, 2, 4, 0,             32'h80000001,  0,             19, 1, 0, 32'hF8000000,  1, 0));
      tab.push_back(row(1, 0, 0, 0, 3, 4, 0,             32'h80000001,  0,             20, 1, 0, 32'h18000000,  1, 0));
      tab.push_back(row(1, 0, 0, 0, 3, 0, 0,             32'h80000001,  0,             21, 1, 0, 32'h80000001,  1, 0));
      tab.push_back(row(0, 0, 0, 0, 0, 0, 1,             1,             0,             22, 0, 0, 2,             0, 0));
      tab.push_back(row(0, 0, 1, 0, 0, 0, 5,             7,             0,             23, 1, 0, 32'hFFFFFFFE,  1, 0));

      // reset state
      tick(); tick();
      exp_wb("reset", 0, 0, 0, 0, 0);
      chk("reset.busy", ia.x_busy, 0);
      chk("reset.ready", 32'(ia.x_ready), 1);
      d_hold = 1; #1;
      chk("reset.ready_hold", 32'(ia.x_ready), 0);
      d_hold = 0;
      reset = 1'b1;
      tick();

      // latency, DEPTH=4
      set_ins(tab[0]);
      tick();
      d_funit = 2'd0;
      chk("lat.busy_e0", ia.x_busy, 32'h8);
      chk("lat.valid_e0", 32'(ia.x_wb_valid), 0);
      tick(); tick();
      chk("lat.valid_e2", 32'(ia.x_wb_valid), 0);
      chk("lat.busy_e2", ia.x_busy, 32'h8);
      tick();
      exp_wb("lat.e3", 1, 3, 1, 12, 0);
      chk("lat.busy_e3", ia.x_busy, 32'h8);
      tick();
      chk("lat.valid_e4", 32'(ia.x_wb_valid), 0);
      chk("lat.busy_e4", ia.x_busy, 0);

      // back-to-back table stream
      for (int k = 0; k < tab.size() + 3; k++) begin
         if (k < tab.size()) set_ins(tab[k]);
         else d_funit = 2'd0;
         tick();
         if (k == 1) chk("stream.busy_e1", ia.x_busy, 32'h8);
         if (k >= 3)
            exp_wb($sformatf("tab%0d", k - 3), 1, tab[k-3].dest, tab[k-3].ew,
                   tab[k-3].ev, tab[k-3].eo);
      end
      d_funit = 2'd0;
      tick();
      chk("stream.drained", 32'(ia.x_wb_valid), 0);

      // same destination in flight, and r0 never busy
      set_ins(pb(32'h1, 12)); tick();
      set_ins(pb(32'h2, 12)); tick();
      set_ins(pb(32'h3, 0));  tick();
      d_funit = 2'd0;
      chk("same.busy_e2", ia.x_busy, 32'h1000);
      tick(); tick();
      chk("same.busy_e4", ia.x_busy, 32'h1000);
      chk("same.wb_e4", ia.x_wb_wbvalue, 32'h2);
      tick();
      chk("same.busy_e5", ia.x_busy, 0);
      chk("same.r0_wb", 32'(ia.x_wb_regdest), 0);
      tick();

      // hold
      set_ins(pb(32'h11, 1)); tick();
      set_ins(pb(32'h22, 2)); tick();
      set_ins(pb(32'h33, 3)); tick();
      d_funit = 2'd0;
      tick();
      exp_wb("hold.e3", 1, 1, 1, 32'h11, 0);
      d_hold = 1;
      set_ins(pb(32'h99, 9));
      #1;
      chk("hold.ready", 32'(ia.x_ready), 0);
      tick();
      exp_wb("hold.e4", 1, 1, 1, 32'h11, 0);
      tick();
      exp_wb("hold.e5", 1, 1, 1, 32'h11, 0);
      chk("hold.busy", ia.x_busy, 32'hE);
      d_hold = 0;
      d_funit = 2'd0;
      tick();
      exp_wb("hold.e6", 1, 2, 1, 32'h22, 0);
      tick();
      exp_wb("hold.e7", 1, 3, 1, 32'h33, 0);
      tick();
      chk("hold.e8_valid", 32'(ia.x_wb_valid), 0);
      tick();
      chk("hold.e9_valid", 32'(ia.x_wb_valid), 0);

      // flush with hold and concurrent issue
      set_ins(pb(32'h44, 4)); tick();
      set_ins(pb(32'h55, 5)); tick();
      set_ins(pb(32'h66, 6)); tick();
      chk("flush.busy_pre", ia.x_busy, 32'h70);
      d_hold = 1; d_flush = 1;
      set_ins(pb(32'h77, 7));
      tick();
      chk("flush.busy", ia.x_busy, 0);
      d_hold = 0; d_flush = 0; d_funit = 2'd0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("flush.valid%0d", i), 32'(ia.x_wb_valid), 0);
         tick();
      end

      // reset with the pipe full
      set_ins(pb(32'hA1, 1)); tick();
      set_ins(pb(32'hA2, 2)); tick();
      set_ins(pb(32'hA3, 3)); tick();
      set_ins(pb(32'hA4, 4)); tick();
      reset = 1'b0; d_hold = 1; d_funit = 2'd0;
      tick();
      exp_wb("rst_mid", 0, 0, 0, 0, 0);
      chk("rst_mid.busy", ia.x_busy, 0);
      chk("rst_mid.ready", 32'(ia.x_ready), 0);
      d_hold = 0;
      tick();
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("rst_mid.valid%0d", i), 32'(ia.x_wb_valid), 0);
      end

      // DEPTH=1 and WIDTH=16 variants
      set_ins(tab[0]);
      tick();
      chk("d1.valid_e0", 32'(ib.x_wb_valid), 1);
      chk("d1.value_e0", ib.x_wb_wbvalue, 12);
      chk("d1.dest_e0", 32'(ib.x_wb_regdest), 3);
      chk("w16.valid_e0", 32'(ic.x_wb_valid), 0);
      set_ins(row(0, 0, 0, 0, 0, 0, 32'h7FFF, 1, 0, 4, 1, 0, 0, 0, 0));
      tick();
      d_funit = 2'd0;
      chk("d1.value_e1", ib.x_wb_wbvalue, 32'h8000);
      chk("d1.wr_e1", 32'(ib.x_wb_writereg), 1);
      chk("d1.ov_e1", 32'(ib.x_wb_overflow), 0);
      chk("d1.busy_e1", ib.x_busy, 32'h10);
      chk("w16.busy_e1", ic.x_busy, 32'h8);
      tick();
      chk("d1.valid_e2", 32'(ib.x_wb_valid), 0);
      chk("w16.valid_e2", 32'(ic.x_wb_valid), 0);
      tick();
      chk("w16.valid_e3", 32'(ic.x_wb_valid), 1);
      chk("w16.value_e3", 32'(ic.x_wb_wbvalue), 12);
      chk("w16.dest_e3", 32'(ic.x_wb_regdest), 3);
      tick();
      chk("w16.value_e4", 32'(ic.x_wb_wbvalue), 32'h8000);
      chk("w16.wr_e4", 32'(ic.x_wb_writereg), 0);
      chk("w16.ov_e4", 32'(ic.x_wb_overflow), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
